// File: rtl/rv32i_ctrl_pkg.sv
// ============================================================================
// Module      : rv32i_ctrl_pkg
// Description : Control bundle types, bubble constants and forwarding select
//               encoding shared by the RV32I control pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_ctrl_pkg;

  // Full decoded control as it sits in the EX stage.
  typedef struct packed {
    logic       write;
    logic       store;
    logic       load;
    logic       branch;
    logic [1:0] alu_a_sel;
    logic       alu_b_sel;
    logic [1:0] next_pc_sel;
    logic [2:0] alu_op;
  } ex_ctrl_t;

  // Control still needed once the instruction has left EX.
  typedef struct packed {
    logic write;
    logic store;
    logic load;
  } mem_ctrl_t;

  // Control still needed in write-back.
  typedef struct packed {
    logic write;
    logic load;
  } wb_ctrl_t;

  // EX operand source select.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  // A bubble carries no side effects at all.
  localparam ex_ctrl_t  EX_BUBBLE  = '0;
  localparam mem_ctrl_t MEM_BUBBLE = '0;
  localparam wb_ctrl_t  WB_BUBBLE  = '0;

  // Narrow the EX bundle to what MEM needs.
  function automatic mem_ctrl_t ex_to_mem(input ex_ctrl_t c);
    mem_ctrl_t m;
    m.write = c.write;
    m.store = c.store;
    m.load  = c.load;
    return m;
  endfunction

  // Narrow the MEM bundle to what WB needs.
  function automatic wb_ctrl_t mem_to_wb(input mem_ctrl_t c);
    wb_ctrl_t w;
    w.write = c.write;
    w.load  = c.load;
    return w;
  endfunction

endpackage : rv32i_ctrl_pkg

`default_nettype wire

// File: rtl/hazard_unit.sv
// ============================================================================
// Module      : hazard_unit
// Description : Purely combinational load-use detection, front-end stall /
//               flush generation and EX operand forwarding selects.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_unit
  import rv32i_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  i_redirect,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_id_uses_rs1,
  input  logic                  i_id_uses_rs2,
  input  logic                  i_ex_valid,
  input  logic                  i_ex_load,
  input  logic                  i_ex_write,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic [REG_ADDR_W-1:0] i_ex_rs1,
  input  logic [REG_ADDR_W-1:0] i_ex_rs2,
  input  logic                  i_ex_uses_rs1,
  input  logic                  i_ex_uses_rs2,
  input  logic                  i_mem_valid,
  input  logic                  i_mem_write,
  input  logic [REG_ADDR_W-1:0] i_mem_rd,
  input  logic                  i_wb_valid,
  input  logic                  i_wb_write,
  input  logic [REG_ADDR_W-1:0] i_wb_rd,
  output logic                  o_load_use,
  output logic                  o_pc_stall,
  output logic                  o_if_id_stall,
  output logic                  o_if_id_flush,
  output logic [1:0]            o_fwd_a_sel,
  output logic [1:0]            o_fwd_b_sel
);

  logic w_ex_load_pending;
  logic w_mem_can_fwd;
  logic w_wb_can_fwd;
  logic w_rs1_hit;
  logic w_rs2_hit;

  // MEM beats WB because it holds the younger value of the register.
  function automatic fwd_sel_e pick_src(
    input logic [REG_ADDR_W-1:0] rs,
    input logic                  uses,
    input logic                  mem_ok,
    input logic [REG_ADDR_W-1:0] mem_rd,
    input logic                  wb_ok,
    input logic [REG_ADDR_W-1:0] wb_rd
  );
    if (mem_ok && uses && (mem_rd == rs)) begin
      return FWD_MEM;
    end else if (wb_ok && uses && (wb_rd == rs)) begin
      return FWD_WB;
    end
    return FWD_RF;
  endfunction

  // Load-use: a live load in EX whose destination the ID instruction reads.
  // Requiring rd != 0 keeps x0 from ever stalling the front end.
  always_comb begin
    w_ex_load_pending = i_ex_valid && i_ex_load && i_ex_write && (i_ex_rd != '0);
    w_rs1_hit         = i_id_uses_rs1 && (i_id_rs1 == i_ex_rd);
    w_rs2_hit         = i_id_uses_rs2 && (i_id_rs2 == i_ex_rd);
    o_load_use        = w_ex_load_pending && (w_rs1_hit || w_rs2_hit);
    // A redirect kills the dependent instruction anyway, so it wins.
    o_pc_stall        = o_load_use && !i_redirect;
    o_if_id_stall     = o_load_use && !i_redirect;
    o_if_id_flush     = i_redirect;
  end

  // Forwarding selects for both EX operands; x0 is never a forwarding source.
  always_comb begin
    w_mem_can_fwd = i_mem_valid && i_mem_write && (i_mem_rd != '0);
    w_wb_can_fwd  = i_wb_valid && i_wb_write && (i_wb_rd != '0);
    o_fwd_a_sel   = pick_src(i_ex_rs1, i_ex_uses_rs1, w_mem_can_fwd, i_mem_rd,
                             w_wb_can_fwd, i_wb_rd);
    o_fwd_b_sel   = pick_src(i_ex_rs2, i_ex_uses_rs2, w_mem_can_fwd, i_mem_rd,
                             w_wb_can_fwd, i_wb_rd);
  end

endmodule : hazard_unit

`default_nettype wire

// File: rtl/control_pipeline.sv
// ============================================================================
// Module      : control_pipeline
// Description : EX/MEM/WB control stage registers for the RV32I 5-stage
//               pipeline, with load-use bubbles and redirect squashing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_pipeline
  import rv32i_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_write,
  input  logic                  id_store,
  input  logic                  id_load,
  input  logic                  id_branch,
  input  logic [1:0]            id_alu_operand_a_selector,
  input  logic                  id_alu_operand_b_selector,
  input  logic [1:0]            id_next_pc_selector,
  input  logic [2:0]            id_alu_operations_selector,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  ex_redirect,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  if_id_flush,
  output logic                  ex_write,
  output logic                  ex_store,
  output logic                  ex_load,
  output logic                  ex_branch,
  output logic [1:0]            ex_alu_operand_a_selector,
  output logic                  ex_alu_operand_b_selector,
  output logic [1:0]            ex_next_pc_selector,
  output logic [2:0]            ex_alu_operations_selector,
  output logic [1:0]            ex_fwd_a_sel,
  output logic [1:0]            ex_fwd_b_sel,
  output logic                  mem_write,
  output logic                  mem_store,
  output logic                  mem_load,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  wb_write,
  output logic                  wb_load,
  output logic [REG_ADDR_W-1:0] wb_rd
);

  // EX stage state
  logic                  r_ex_valid;
  ex_ctrl_t              r_ex_ctrl;
  logic [REG_ADDR_W-1:0] r_ex_rd;
  logic [REG_ADDR_W-1:0] r_ex_rs1;
  logic [REG_ADDR_W-1:0] r_ex_rs2;
  logic                  r_ex_uses_rs1;
  logic                  r_ex_uses_rs2;

  // MEM stage state
  logic                  r_mem_valid;
  mem_ctrl_t             r_mem_ctrl;
  logic [REG_ADDR_W-1:0] r_mem_rd;

  // WB stage state
  logic                  r_wb_valid;
  wb_ctrl_t              r_wb_ctrl;
  logic [REG_ADDR_W-1:0] r_wb_rd;

  ex_ctrl_t              w_id_ctrl;
  ex_ctrl_t              w_ex_ctrl;
  mem_ctrl_t             w_mem_ctrl;
  wb_ctrl_t              w_wb_ctrl;
  logic [REG_ADDR_W-1:0] w_mem_rd;
  logic [REG_ADDR_W-1:0] w_wb_rd;
  logic                  w_redirect;
  logic                  w_load_use;
  logic                  w_ex_bubble;

  // Pack the decoded ID control into the stage bundle.
  always_comb begin
    w_id_ctrl             = EX_BUBBLE;
    w_id_ctrl.write       = id_write;
    w_id_ctrl.store       = id_store;
    w_id_ctrl.load        = id_load;
    w_id_ctrl.branch      = id_branch;
    w_id_ctrl.alu_a_sel   = id_alu_operand_a_selector;
    w_id_ctrl.alu_b_sel   = id_alu_operand_b_selector;
    w_id_ctrl.next_pc_sel = id_next_pc_selector;
    w_id_ctrl.alu_op      = id_alu_operations_selector;
  end

  // Valid-gated view of every stage: an empty slot shows no control and rd 0.
  always_comb begin
    w_ex_ctrl  = r_ex_valid  ? r_ex_ctrl  : EX_BUBBLE;
    w_mem_ctrl = r_mem_valid ? r_mem_ctrl : MEM_BUBBLE;
    w_wb_ctrl  = r_wb_valid  ? r_wb_ctrl  : WB_BUBBLE;
    w_mem_rd   = r_mem_valid ? r_mem_rd   : '0;
    w_wb_rd    = r_wb_valid  ? r_wb_rd    : '0;
  end

  // A redirect seen while reset is held must not flush the front end.
  assign w_redirect  = ex_redirect && rst_n;
  assign w_ex_bubble = w_redirect || w_load_use;

  hazard_unit #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard_unit (
    .i_redirect    (w_redirect),
    .i_id_rs1      (id_rs1),
    .i_id_rs2      (id_rs2),
    .i_id_uses_rs1 (id_uses_rs1),
    .i_id_uses_rs2 (id_uses_rs2),
    .i_ex_valid    (r_ex_valid),
    .i_ex_load     (w_ex_ctrl.load),
    .i_ex_write    (w_ex_ctrl.write),
    .i_ex_rd       (r_ex_rd),
    .i_ex_rs1      (r_ex_rs1),
    .i_ex_rs2      (r_ex_rs2),
    .i_ex_uses_rs1 (r_ex_uses_rs1),
    .i_ex_uses_rs2 (r_ex_uses_rs2),
    .i_mem_valid   (r_mem_valid),
    .i_mem_write   (w_mem_ctrl.write),
    .i_mem_rd      (w_mem_rd),
    .i_wb_valid    (r_wb_valid),
    .i_wb_write    (w_wb_ctrl.write),
    .i_wb_rd       (w_wb_rd),
    .o_load_use    (w_load_use),
    .o_pc_stall    (pc_stall),
    .o_if_id_stall (if_id_stall),
    .o_if_id_flush (if_id_flush),
    .o_fwd_a_sel   (ex_fwd_a_sel),
    .o_fwd_b_sel   (ex_fwd_b_sel)
  );

  // EX register: capture ID, or take a bubble on load-use or redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid    <= 1'b0;
      r_ex_ctrl     <= EX_BUBBLE;
      r_ex_rd       <= '0;
      r_ex_rs1      <= '0;
      r_ex_rs2      <= '0;
      r_ex_uses_rs1 <= 1'b0;
      r_ex_uses_rs2 <= 1'b0;
    end else if (w_ex_bubble) begin
      r_ex_valid    <= 1'b0;
      r_ex_ctrl     <= EX_BUBBLE;
      r_ex_rd       <= '0;
      r_ex_rs1      <= '0;
      r_ex_rs2      <= '0;
      r_ex_uses_rs1 <= 1'b0;
      r_ex_uses_rs2 <= 1'b0;
    end else begin
      r_ex_valid    <= 1'b1;
      r_ex_ctrl     <= w_id_ctrl;
      r_ex_rd       <= id_rd;
      r_ex_rs1      <= id_rs1;
      r_ex_rs2      <= id_rs2;
      r_ex_uses_rs1 <= id_uses_rs1;
      r_ex_uses_rs2 <= id_uses_rs2;
    end
  end

  // MEM register: always advances; the EX instruction proceeds even on redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_valid <= 1'b0;
      r_mem_ctrl  <= MEM_BUBBLE;
      r_mem_rd    <= '0;
    end else begin
      r_mem_valid <= r_ex_valid;
      r_mem_ctrl  <= ex_to_mem(w_ex_ctrl);
      r_mem_rd    <= r_ex_valid ? r_ex_rd : '0;
    end
  end

  // WB register: always advances from MEM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid <= 1'b0;
      r_wb_ctrl  <= WB_BUBBLE;
      r_wb_rd    <= '0;
    end else begin
      r_wb_valid <= r_mem_valid;
      r_wb_ctrl  <= mem_to_wb(w_mem_ctrl);
      r_wb_rd    <= w_mem_rd;
    end
  end

  assign ex_write                   = w_ex_ctrl.write;
  assign ex_store                   = w_ex_ctrl.store;
  assign ex_load                    = w_ex_ctrl.load;
  assign ex_branch                  = w_ex_ctrl.branch;
  assign ex_alu_operand_a_selector  = w_ex_ctrl.alu_a_sel;
  assign ex_alu_operand_b_selector  = w_ex_ctrl.alu_b_sel;
  assign ex_next_pc_selector        = w_ex_ctrl.next_pc_sel;
  assign ex_alu_operations_selector = w_ex_ctrl.alu_op;

  assign mem_write = w_mem_ctrl.write;
  assign mem_store = w_mem_ctrl.store;
  assign mem_load  = w_mem_ctrl.load;
  assign mem_rd    = w_mem_rd;

  assign wb_write  = w_wb_ctrl.write;
  assign wb_load   = w_wb_ctrl.load;
  assign wb_rd     = w_wb_rd;

endmodule : control_pipeline

`default_nettype wire

// File: tb/tb_control_pipeline.sv
// ============================================================================
// Module      : tb_control_pipeline
// Description : Self-checking bench for control_pipeline: directed scenarios
//               plus a random instruction stream against a queue-style model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_pipeline;

  localparam int RW = 5;

  // One in-flight instruction as the model sees it.
  // ctl = {write, store, load, branch, a_sel[1:0], b_sel, npc_sel[1:0], alu_op[2:0]}
  typedef struct packed {
    logic          v;
    logic [11:0]   ctl;
    logic [RW-1:0] rd;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic          u1;
    logic          u2;
  } ins_t;

  localparam logic [11:0] C_ADDI = 12'b1000_00_1_00_000;
  localparam logic [11:0] C_LW   = 12'b1010_00_1_00_000;
  localparam logic [11:0] C_ADD  = 12'b1000_00_0_00_000;
  localparam logic [11:0] C_BR   = 12'b0001_00_0_01_000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ins_t id_i;
  logic redir_i;

  // Model pipeline contents (index 0 = EX, 1 = MEM, 2 = WB)
  ins_t m_pipe [3];

  int checks = 0;
  int errors = 0;

  logic          pc_stall, if_id_stall, if_id_flush;
  logic          ex_write, ex_store, ex_load, ex_branch;
  logic [1:0]    ex_a, ex_npc, ex_fwd_a_sel, ex_fwd_b_sel;
  logic          ex_b;
  logic [2:0]    ex_op;
  logic          mem_write, mem_store, mem_load, wb_write, wb_load;
  logic [RW-1:0] mem_rd, wb_rd;

  control_pipeline #(.REG_ADDR_W(RW)) dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .id_write                   (id_i.ctl[11]),
    .id_store                   (id_i.ctl[10]),
    .id_load                    (id_i.ctl[9]),
    .id_branch                  (id_i.ctl[8]),
    .id_alu_operand_a_selector  (id_i.ctl[7:6]),
    .id_alu_operand_b_selector  (id_i.ctl[5]),
    .id_next_pc_selector        (id_i.ctl[4:3]),
    .id_alu_operations_selector (id_i.ctl[2:0]),
    .id_rs1                     (id_i.rs1),
    .id_rs2                     (id_i.rs2),
    .id_rd                      (id_i.rd),
    .id_uses_rs1                (id_i.u1),
    .id_uses_rs2                (id_i.u2),
    .ex_redirect                (redir_i),
    .pc_stall                   (pc_stall),
    .if_id_stall                (if_id_stall),
    .if_id_flush                (if_id_flush),
    .ex_write                   (ex_write),
    .ex_store                   (ex_store),
    .ex_load                    (ex_load),
    .ex_branch                  (ex_branch),
    .ex_alu_operand_a_selector  (ex_a),
    .ex_alu_operand_b_selector  (ex_b),
    .ex_next_pc_selector        (ex_npc),
    .ex_alu_operations_selector (ex_op),
    .ex_fwd_a_sel               (ex_fwd_a_sel),
    .ex_fwd_b_sel               (ex_fwd_b_sel),
    .mem_write                  (mem_write),
    .mem_store                  (mem_store),
    .mem_load                   (mem_load),
    .mem_rd                     (mem_rd),
    .wb_write                   (wb_write),
    .wb_load                    (wb_load),
    .wb_rd                      (wb_rd)
  );

  function automatic ins_t mk(input logic [11:0] c, input int rd, input int rs1,
                              input logic u1, input int rs2, input logic u2);
    ins_t t;
    t.v   = 1'b1;
    t.ctl = c;
    t.rd  = RW'(rd);
    t.rs1 = RW'(rs1);
    t.rs2 = RW'(rs2);
    t.u1  = u1;
    t.u2  = u2;
    return t;
  endfunction

  // Would the ID instruction read a register a load in EX has yet to produce?
  function automatic bit model_load_use();
    ins_t e = m_pipe[0];
    if (!(e.v && e.ctl[9] && e.ctl[11] && e.rd != 0)) return 1'b0;
    return (id_i.u1 && id_i.rs1 == e.rd) || (id_i.u2 && id_i.rs2 == e.rd);
  endfunction

  // Where should an EX operand come from? Youngest writer of a nonzero reg wins.
  function automatic logic [1:0] model_src(input logic [RW-1:0] rs, input logic u);
    if (u && m_pipe[1].v && m_pipe[1].ctl[11] && m_pipe[1].rd != 0 && m_pipe[1].rd == rs)
      return 2'b01;
    if (u && m_pipe[2].v && m_pipe[2].ctl[11] && m_pipe[2].rd != 0 && m_pipe[2].rd == rs)
      return 2'b10;
    return 2'b00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic lu;
    logic [11:0] exp_ex;
    lu = rst_n && model_load_use();
    exp_ex = m_pipe[0].v ? m_pipe[0].ctl : 12'h0;
    chk("pc_stall", 32'(pc_stall), 32'(lu && !redir_i));
    chk("if_id_stall", 32'(if_id_stall), 32'(lu && !redir_i));
    chk("if_id_flush", 32'(if_id_flush), 32'(rst_n && redir_i));
    chk("ex_ctl", 32'({ex_write, ex_store, ex_load, ex_branch, ex_a, ex_b, ex_npc, ex_op}),
        32'(exp_ex));
    chk("fwd", 32'({ex_fwd_a_sel, ex_fwd_b_sel}),
        32'({model_src(m_pipe[0].rs1, m_pipe[0].u1), model_src(m_pipe[0].rs2, m_pipe[0].u2)}));
    chk("mem", 32'({mem_write, mem_store, mem_load, mem_rd}),
        m_pipe[1].v ? 32'({m_pipe[1].ctl[11:9], m_pipe[1].rd}) : 32'h0);
    chk("wb", 32'({wb_write, wb_load, wb_rd}),
        m_pipe[2].v ? 32'({m_pipe[2].ctl[11], m_pipe[2].ctl[9], m_pipe[2].rd}) : 32'h0);
  endtask

  // Apply inputs and let combinational outputs settle (called at negedge).
  task automatic peek(input ins_t id, input logic r);
    id_i    = id;
    redir_i = r;
    #1;
  endtask

  // One cycle: drive, check against model, clock, advance model.
  task automatic step(input ins_t id, input logic r, output bit stalled);
    bit bub;
    id_i    = id;
    redir_i = r;
    #2;
    check_all();
    bub     = r || model_load_use();
    stalled = model_load_use() && !r;
    @(posedge clk);
    if (rst_n) begin
      m_pipe[2] = m_pipe[1];
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = bub ? ins_t'(0) : id;
    end
    @(negedge clk);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) m_pipe[i] = '0;
  endtask

  ins_t cur, prv;
  bit   st;

  initial begin
    model_clear();
    id_i    = mk(C_ADDI, 1, 0, 0, 0, 0);
    redir_i = 1'b1;
    #3;
    // Reset state, with a redirect asserted to show flush stays low.
    check_all();
    chk("rst_flush", 32'(if_id_flush), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after release captures ID
    step(mk(C_ADDI, 1, 0, 1, 0, 0), 1'b0, st);
    chk("rel_ex_write", 32'(ex_write), 32'h1);
    chk("rel_ex_bsel", 32'(ex_b), 32'h1);

    // Load-use: lw x5 then add x6, x5, x2
    step(mk(C_LW, 5, 1, 1, 0, 0), 1'b0, st);
    peek(mk(C_ADD, 6, 5, 1, 2, 1), 1'b0);
    chk("lu_pc_stall", 32'(pc_stall), 32'h1);
    chk("lu_if_id_stall", 32'(if_id_stall), 32'h1);
    step(mk(C_ADD, 6, 5, 1, 2, 1), 1'b0, st);
    chk("lu_ex_bubble", 32'({ex_write, ex_load, ex_a, ex_b, ex_op}), 32'h0);
    peek(mk(C_ADD, 6, 5, 1, 2, 1), 1'b0);
    chk("lu_one_cycle", 32'(pc_stall), 32'h0);
    step(mk(C_ADD, 6, 5, 1, 2, 1), 1'b0, st);
    chk("lu_fwd_a_wb", 32'(ex_fwd_a_sel), 32'h2);

    // Redirect while addi sits in ID
    step(mk(C_BR, 0, 1, 1, 2, 1), 1'b0, st);
    peek(mk(C_ADDI, 3, 0, 1, 0, 0), 1'b1);
    chk("redir_flush", 32'(if_id_flush), 32'h1);
    step(mk(C_ADDI, 3, 0, 1, 0, 0), 1'b1, st);
    chk("redir_ex_zero", 32'({ex_write, ex_store, ex_load, ex_branch, ex_a, ex_b, ex_npc, ex_op}),
        32'h0);
    chk("redir_mem_write", 32'(mem_write), 32'h0);

    // Load-use and redirect together
    step(mk(C_LW, 5, 1, 1, 0, 0), 1'b0, st);
    peek(mk(C_ADD, 6, 5, 1, 2, 1), 1'b1);
    chk("both_pc_stall", 32'(pc_stall), 32'h0);
    chk("both_flush", 32'(if_id_flush), 32'h1);
    step(mk(C_ADD, 6, 5, 1, 2, 1), 1'b1, st);
    chk("both_ex_bubble", 32'({ex_write, ex_load, ex_b}), 32'h0);

    // Forward priority: MEM and WB both write x7
    step(mk(C_ADDI, 7, 0, 1, 0, 0), 1'b0, st);
    step(mk(C_ADDI, 7, 0, 1, 0, 0), 1'b0, st);
    step(mk(C_ADD, 8, 1, 1, 7, 1), 1'b0, st);
    chk("fwd_b_mem_prio", 32'(ex_fwd_b_sel), 32'h1);
    step(mk(C_ADDI, 7, 0, 1, 0, 0), 1'b0, st);
    step(mk(C_ADDI, 0, 0, 1, 0, 0), 1'b0, st);
    step(mk(C_ADD, 8, 1, 1, 7, 1), 1'b0, st);
    chk("fwd_b_wb", 32'(ex_fwd_b_sel), 32'h2);

    // x0 never stalls or forwards
    step(mk(C_LW, 0, 1, 1, 0, 0), 1'b0, st);
    peek(mk(C_ADD, 9, 0, 1, 0, 1), 1'b0);
    chk("x0_no_stall", 32'(pc_stall), 32'h0);
    step(mk(C_ADD, 9, 0, 1, 0, 1), 1'b0, st);
    chk("x0_no_fwd", 32'({ex_fwd_a_sel, ex_fwd_b_sel}), 32'h0);

    // Random stream; a stalled instruction is re-presented like a real IF/ID
    st = 1'b0;
    prv = '0;
    for (int n = 0; n < 400; n++) begin
      if (st) begin
        cur = prv;
      end else begin
        cur.v   = 1'b1;
        cur.ctl = 12'($urandom);
        cur.rd  = RW'($urandom_range(0, 3));
        cur.rs1 = RW'($urandom_range(0, 3));
        cur.rs2 = RW'($urandom_range(0, 3));
        cur.u1  = 1'($urandom);
        cur.u2  = 1'($urandom);
      end
      prv = cur;
      step(cur, 1'($urandom_range(0, 7) == 0), st);
    end

    // Asynchronous reset in the middle of a load-use stall
    step(mk(C_LW, 5, 1, 1, 0, 0), 1'b0, st);
    peek(mk(C_ADD, 6, 5, 1, 2, 1), 1'b0);
    chk("pre_rst_stall", 32'(pc_stall), 32'h1);
    rst_n   = 1'b0;
    redir_i = 1'b1;
    #1;
    chk("rst_async_zero",
        32'({pc_stall, if_id_stall, if_id_flush, ex_write, ex_store, ex_load, ex_branch,
             ex_a, ex_b, ex_npc, ex_op, ex_fwd_a_sel, ex_fwd_b_sel}), 32'h0);
    chk("rst_async_back",
        32'({mem_write, mem_store, mem_load, mem_rd, wb_write, wb_load, wb_rd}), 32'h0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    step(mk(C_ADDI, 1, 0, 1, 0, 0), 1'b0, st);
    chk("rel2_ex_write", 32'(ex_write), 32'h1);
    chk("rel2_ex_bsel", 32'(ex_b), 32'h1);
    step(mk(C_ADD, 2, 1, 1, 0, 0), 1'b0, st);
    chk("rel2_fwd_a_mem", 32'(ex_fwd_a_sel), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_control_pipeline

`default_nettype wire

// File: doc/control_pipeline.md
# control_pipeline

Carries the control bundle produced by `control_decoder` from ID through EX, MEM and WB in the RV32I 5-stage pipeline, and owns the pipeline hazard logic. It detects load-use hazards and stalls PC and IF/ID for exactly one cycle, inserting a bubble into EX. It squashes wrong-path instructions on a redirect resolved in EX. It drives the EX operand forwarding selects.

## Interface
- Parameters
  - `REG_ADDR_W`, default 5: register-index width.
- Ports
  - `clk` input, 1: rising-edge clock.
  - `rst_n` input, 1: asynchronous reset, active-low.
  - `id_write`, `id_store`, `id_load`, `id_branch` input, 1 each: decoded ID control from `control_decoder`.
  - `id_alu_operand_a_selector` input, 2; `id_alu_operand_b_selector` input, 1; `id_next_pc_selector` input, 2; `id_alu_operations_selector` input, 3: decoded ID control.
  - `id_rs1`, `id_rs2`, `id_rd` input, `REG_ADDR_W` each: register indices of the ID instruction.
  - `id_uses_rs1`, `id_uses_rs2` input, 1 each: the ID instruction reads the register.
  - `ex_redirect` input, 1: EX resolved a taken branch, `jal` or `jalr`.
  - `pc_stall`, `if_id_stall`, `if_id_flush` output, 1 each: front-end control.
  - `ex_write`, `ex_store`, `ex_load`, `ex_branch`, `ex_alu_operand_a_selector`, `ex_alu_operand_b_selector`, `ex_next_pc_selector`, `ex_alu_operations_selector` output: registered EX control, same widths as the ID inputs.
  - `ex_fwd_a_sel`, `ex_fwd_b_sel` output, 2 each: forwarding select. 00 = register file, 01 = EX/MEM result, 10 = MEM/WB result.
  - `mem_write`, `mem_store`, `mem_load` output, 1 each; `mem_rd` output, `REG_ADDR_W`.
  - `wb_write`, `wb_load` output, 1 each; `wb_rd` output, `REG_ADDR_W`.

## Operation
- Stage registers for EX, MEM and WB. Each stage holds a valid bit, its control bundle and `rd`. EX also holds `rs1`, `rs2`, `uses_rs1` and `uses_rs2`.
- Valid gating:
  - Every control output is ANDed with its stage's valid bit.
  - An invalid stage drives all-zero control and `rd` = 0.
- Load-use hazard (`load_use`) is asserted when all of the following hold:
  - EX valid, `ex_load`, `ex_write`, and EX rd ≠ 0;
  - and either (`id_uses_rs1` and `id_rs1` = EX rd) or (`id_uses_rs2` and `id_rs2` = EX rd).
- On `load_use` with no redirect:
  - `pc_stall` = `if_id_stall` = 1.
  - The EX register loads a bubble (valid = 0).
  - MEM and WB advance normally.
- On `ex_redirect`:
  - `if_id_flush` = 1.
  - The EX register loads a bubble; the ID instruction is squashed.
  - The instruction in EX proceeds to MEM.
  - `pc_stall` and `if_id_stall` are forced to 0; redirect beats load-use.
- Otherwise:
  - EX captures the ID bundle with valid = 1.
  - MEM captures EX, and WB captures MEM, including valid.
- Forwarding, evaluated per operand (shown for A; B identical with rs2):
  - 01 if MEM valid, `mem_write`, `mem_rd` ≠ 0, EX `uses_rs1`, and `mem_rd` = EX rs1.
  - Else 10 if WB valid, `wb_write`, `wb_rd` ≠ 0, EX `uses_rs1`, and `wb_rd` = EX rs1.
  - Else 00.
  - MEM has priority over WB.
- x0 never causes a stall or a forward.

## Timing
- All stage registers update on the rising edge of `clk`.
- Hazard, forwarding and front-end outputs are combinational from the current stage state and the ID inputs, within the same cycle.
- Load-use costs exactly one bubble. In the following cycle the load is in MEM, so `load_use` deasserts and the dependent instruction enters EX.
- Redirect latency: the squash takes effect at the edge following `ex_redirect`. Two wrong-path slots are killed: IF/ID via `if_id_flush`, and ID via the EX bubble.
- Reset (`rst_n` low, asynchronous, at any time, including mid-stall):
  - All valid bits and control bits = 0, all rd/rs = 0.
  - `pc_stall` = `if_id_stall` = `if_id_flush` = 0.
  - `ex_fwd_*_sel` = 00.
- Release: the first edge after `rst_n` rises captures ID normally.

## Structure
- Package `rv32i_ctrl_pkg`:
  - typedef structs `ex_ctrl_t`, `mem_ctrl_t`, `wb_ctrl_t`;
  - enum `fwd_sel_e` (FWD_RF = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10);
  - constant `BUBBLE` values for each struct.
- One combinational sub-module, `hazard_unit`, computes `load_use`, the front-end controls and both forwarding selects. The stage registers stay in `control_pipeline`.

## Test plan
- Reset: assert `rst_n` = 0 mid-stream.
  - Expect all outputs 0 immediately, without a clock edge.
  - After release, an `addi x1` (write = 1, b_sel = 1) appears on `ex_*` one edge later.
- Load-use: `lw x5` in EX, `add x6, x5, x2` in ID (rs1 = 5).
  - Expect `pc_stall` = `if_id_stall` = 1 for one cycle and EX bubble next.
  - Then `add` in EX with `ex_fwd_a_sel` = 10.
- Redirect: `ex_redirect` = 1 while `addi` is in ID.
  - Expect `if_id_flush` = 1 and EX all-zero next cycle.
  - The branch proceeds to MEM with `mem_write` = 0.
- Simultaneous: `load_use` and `ex_redirect` in the same cycle.
  - Expect `pc_stall` = 0, `if_id_flush` = 1 and an EX bubble.
- Forward priority: MEM and WB both write x7; EX reads x7 as rs2.
  - Expect `ex_fwd_b_sel` = 01.
  - With MEM rd = 0, expect 10.
- x0: `lw x0` in EX, ID reads x0.
  - Expect no stall and `ex_fwd_*_sel` = 00.
